fp_operand_import: RTL and testbench

//  Front end of the 32-bit FP ALU. Accepts raw IEEE-754 operands A,B and an opcode over valid/ready.

---
 rtl/fp_import_pkg.sv | 41 ++++
 rtl/fp_operand_import_if.sv | 36 +++
 rtl/fp_classify.sv | 42 ++++
 rtl/fp_operand_import.sv | 131 +++++++++++++
 tb/tb_fp_operand_import.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_import_pkg.sv
// Shared types and constants for the FP ALU operand-import front end.
package fp_import_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MULT = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  // Bit positions inside the 6-bit special code {zA,iA,nA,zB,iB,nB}
  localparam int SPC_ZA = 5;
  localparam int SPC_IA = 4;
  localparam int SPC_NA = 3;
  localparam int SPC_ZB = 2;
  localparam int SPC_IB = 1;
  localparam int SPC_NB = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
    logic              inf;
    logic              nan;
  } operand_t;

  typedef struct packed {
    logic [31:0] a_raw;
    logic [31:0] b_raw;
    op_e         op;
    operand_t    a;
    operand_t    b;
  } op_rec_t;

endpackage

// File: rtl/fp_operand_import_if.sv
// Operand-import handshake bundle: upstream valid/ready/data and unpacked downstream fields.
interface fp_operand_import_if #(parameter int TAG_W = 4);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_a_raw;
  logic [31:0]       out_b_raw;
  logic [1:0]        out_op;
  logic              out_a_sign;
  logic              out_b_sign;
  logic [7:0]        out_a_exp;
  logic [7:0]        out_b_exp;
  logic [23:0]       out_a_mant;
  logic [23:0]       out_b_mant;
  logic [5:0]        out_special;
  logic              out_bypass;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_a_raw, out_b_raw, out_op, out_a_sign, out_b_sign,
           out_a_exp, out_b_exp, out_a_mant, out_b_mant, out_special, out_bypass, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_a_raw, out_b_raw, out_op, out_a_sign, out_b_sign,
           out_a_exp, out_b_exp, out_a_mant, out_b_mant, out_special, out_bypass, out_tag
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational unpack/classify of one IEEE-754 single operand.
// Denormal handling selected by FP_IMPORT_DENORM_FLUSH_EN.
module fp_classify
  import fp_import_pkg::*;
(
  input  logic [31:0] x,
  output operand_t    y
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac;

  assign exp_f = x[FRAC_W +: EXP_W];
  assign frac  = x[FRAC_W-1:0];

  // NOTE: every field gets a default before the branches so no latch is inferred.
  always_comb begin
    y      = '0;
    y.sign = x[31];
    y.exp  = exp_f;
    y.mant = {1'b1, frac};
    if (exp_f == EXP_SPECIAL) begin
      y.inf = (frac == '0);
      y.nan = (frac != '0);
    end else if (exp_f == '0) begin
      if (frac == '0) begin
        y.zero = 1'b1;
        y.mant = '0;
      end else begin
`ifdef FP_IMPORT_DENORM_FLUSH_EN
        y.zero = 1'b1;
        y.mant = '0;
`else
        // Denormal scale equals exponent 1 with no hidden bit
        y.mant = {1'b0, frac};
        y.exp  = 8'd1;
`endif
      end
    end
  end

endmodule

// File: rtl/fp_operand_import.sv
// FP ALU front end: classifies A/B, tags each op, and buffers it in a 2-entry skid (main/skid).
// Build option FP_IMPORT_DENORM_FLUSH_EN (see fp_classify).
module fp_operand_import
  import fp_import_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  fp_operand_import_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e            state_q, state_n;
  logic              ready_q;
  logic              out_valid;
  logic              accept, drain;
  logic              load_main, load_skid, main_from_skid;
  operand_t          cls_a, cls_b;
  op_rec_t           new_rec, main_q, skid_q;
  logic [TAG_W-1:0]  tag_q, main_tag_q, skid_tag_q;
  logic [5:0]        special;

  fp_classify u_cls_a (.x(bus.in_a), .y(cls_a));
  fp_classify u_cls_b (.x(bus.in_b), .y(cls_b));

  always_comb begin
    new_rec        = '0;
    new_rec.a_raw  = bus.in_a;
    new_rec.b_raw  = bus.in_b;
    new_rec.op     = op_e'(bus.in_op);
    new_rec.a      = cls_a;
    new_rec.b      = cls_b;
    new_rec.b.sign = cls_b.sign ^ (op_e'(bus.in_op) == OP_SUB);
  end

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid && ready_q;
  assign drain     = out_valid && bus.out_ready;

  always_comb begin
    state_n        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_n   = ONE;
        load_main = 1'b1;
      end
      ONE: begin
        if (accept && !drain) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_main = 1'b1;
        end else if (drain) begin
          state_n = EMPTY;
        end
      end
      TWO: if (drain) begin
        state_n        = ONE;
        main_from_skid = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_n;
      ready_q <= (state_n != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_tag_q <= '0;
      tag_q      <= '0;
    end else begin
      if (load_main) begin
        main_q     <= new_rec;
        main_tag_q <= tag_q;
      end else if (main_from_skid) begin
        main_q     <= skid_q;
        main_tag_q <= skid_tag_q;
      end
      if (accept) tag_q <= tag_q + TAG_W'(1);
    end
  end

  // NOTE: skid storage is not reset; it is only read after being loaded, and outputs come from main.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q     <= new_rec;
      skid_tag_q <= tag_q;
    end
  end

  always_comb begin
    special         = '0;
    special[SPC_ZA] = main_q.a.zero;
    special[SPC_IA] = main_q.a.inf;
    special[SPC_NA] = main_q.a.nan;
    special[SPC_ZB] = main_q.b.zero;
    special[SPC_IB] = main_q.b.inf;
    special[SPC_NB] = main_q.b.nan;
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_a_raw   = main_q.a_raw;
  assign bus.out_b_raw   = main_q.b_raw;
  assign bus.out_op      = main_q.op;
  assign bus.out_a_sign  = main_q.a.sign;
  assign bus.out_b_sign  = main_q.b.sign;
  assign bus.out_a_exp   = main_q.a.exp;
  assign bus.out_b_exp   = main_q.b.exp;
  assign bus.out_a_mant  = main_q.a.mant;
  assign bus.out_b_mant  = main_q.b.mant;
  assign bus.out_special = special;
  assign bus.out_bypass  = |special;
  assign bus.out_tag     = main_tag_q;

endmodule

// File: tb/tb_fp_operand_import.sv
// Directed bench for fp_operand_import with a scoreboard queue of expected outputs.
module tb_fp_operand_import;

  localparam int TAG_W = 4;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        z, i, n;
  } cls_t;

  typedef struct {
    logic [31:0]      a_raw, b_raw;
    logic [1:0]       op;
    logic             as, bs;
    logic [7:0]       ae, be;
    logic [23:0]      am, bm;
    logic [5:0]       spc;
    logic             byp;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  logic [TAG_W-1:0] tag_m;
  exp_t sb[$];

  fp_operand_import_if #(.TAG_W(TAG_W)) bus ();
  fp_operand_import #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic cls_t cls_m(input logic [31:0] x);
    cls_t c;
    c.s = x[31]; c.e = x[30:23]; c.m = {1'b1, x[22:0]};
    c.z = 1'b0;  c.i = 1'b0;     c.n = 1'b0;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'd0) c.i = 1'b1; else c.n = 1'b1;
    end else if (x[30:0] == 31'd0) begin
      c.z = 1'b1; c.m = 24'd0;
    end else if (x[30:23] == 8'd0) begin
`ifdef FP_IMPORT_DENORM_FLUSH_EN
      c.z = 1'b1; c.m = 24'd0; c.e = 8'd0;
`else
      c.m = {1'b0, x[22:0]}; c.e = 8'd1;
`endif
    end
    return c;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [TAG_W-1:0] tag);
    exp_t r;
    cls_t ca, cb;
    ca = cls_m(a); cb = cls_m(b);
    r.a_raw = a; r.b_raw = b; r.op = op;
    r.as = ca.s; r.bs = (op == 2'b01) ? ~cb.s : cb.s;
    r.ae = ca.e; r.be = cb.e; r.am = ca.m; r.bm = cb.m;
    r.spc = {ca.z, ca.i, ca.n, cb.z, cb.i, cb.n};
    r.byp = (r.spc != 6'd0);
    r.tag = tag;
    return r;
  endfunction

  function automatic logic [159:0] out_vec();
    return {17'd0, bus.out_a_raw, bus.out_b_raw, bus.out_op, bus.out_a_sign, bus.out_b_sign,
            bus.out_a_exp, bus.out_b_exp, bus.out_a_mant, bus.out_b_mant,
            bus.out_special, bus.out_bypass, bus.out_tag};
  endfunction

  task automatic compare(input exp_t e);
    check("a_raw",   bus.out_a_raw,   e.a_raw);
    check("b_raw",   bus.out_b_raw,   e.b_raw);
    check("op",      bus.out_op,      e.op);
    check("a_sign",  bus.out_a_sign,  e.as);
    check("b_sign",  bus.out_b_sign,  e.bs);
    check("a_exp",   bus.out_a_exp,   e.ae);
    check("b_exp",   bus.out_b_exp,   e.be);
    check("a_mant",  bus.out_a_mant,  e.am);
    check("b_mant",  bus.out_b_mant,  e.bm);
    check("special", bus.out_special, e.spc);
    check("bypass",  bus.out_bypass,  e.byp);
    check("tag",     bus.out_tag,     e.tag);
  endtask

  // Output monitor: sampled mid-cycle, a transfer happens at the following rising edge
  logic [159:0] snap;
  logic         held = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      if (held) check("hold_stable", out_vec(), snap);
      if (bus.out_ready) begin
        n_out++;
        check("sb_has_entry", 160'(sb.size() > 0), 160'(1));
        if (sb.size() > 0) compare(sb.pop_front());
        held = 1'b0;
      end else begin
        snap = out_vec();
        held = 1'b1;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    check("accept_in_time", 160'(ok), 160'(1));
    @(posedge clk);
    if (ok) begin
      sb.push_back(model(a, b, op, tag_m));
      tag_m++;
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tag_m = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    check("ready_after_reset", 160'(ok), 160'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, o0;
    rst = 1'b1; tag_m = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_tag",       bus.out_tag,   0);
    check("rst_special",   bus.out_special, 0);
    check("rst_a_raw",     bus.out_a_raw, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: basic add
    bus.out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 2'b00);
    @(negedge clk);
    check("t1_valid",  bus.out_valid,  1);
    check("t1_a_exp",  bus.out_a_exp,  8'h7F);
    check("t1_a_mant", bus.out_a_mant, 24'h800000);
    check("t1_b_exp",  bus.out_b_exp,  8'h80);
    check("t1_bypass", bus.out_bypass, 0);
    check("t1_tag",    bus.out_tag,    0);
    @(posedge clk); #1;

    // 2: special classes
    send(32'h00000000, 32'h7F800000, 2'b10);
    @(negedge clk);
    check("t2_spc_zero_inf", bus.out_special, 6'b100010);
    check("t2_bypass",       bus.out_bypass,  1);
    @(posedge clk); #1;
    send(32'h7FC00000, 32'h80000000, 2'b00);
    @(negedge clk);
    check("t2_spc_nan_zero", bus.out_special, 6'b001100);
    @(posedge clk); #1;
    send(32'hFF800000, 32'h3F800000, 2'b00);
    @(negedge clk);
    check("t2_infA", bus.out_special[4], 1);
    check("t2_signA", bus.out_a_sign, 1);
    @(posedge clk); #1;

    // 3: subtract flips only B sign
    send(32'h3F800000, 32'h40000000, 2'b01);
    @(negedge clk);
    check("t3_b_sign", bus.out_b_sign, 1);
    check("t3_b_raw",  bus.out_b_raw,  32'h40000000);
    @(posedge clk); #1;

    // 4: backpressure fills main and skid
    bus.out_ready = 1'b0;
    send(32'h40400000, 32'h40800000, 2'b10);
    send(32'h40A00000, 32'h40C00000, 2'b11);
    @(negedge clk);
    check("t4_in_ready_low", bus.in_ready,  0);
    check("t4_out_valid",    bus.out_valid, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_drained", 160'(sb.size()), 0);
    check("t4_idle",    bus.out_valid, 0);
    @(posedge clk); #1;

    // 5: full-throughput stream with tag wrap
    do_reset();
    wait_ready();
    t0 = cyc; o0 = n_out;
    for (int i = 0; i < 20; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)));
    check("t5_cycles", 160'(cyc - t0), 20);
    repeat (2) @(negedge clk);
    check("t5_outputs", 160'(n_out - o0), 20);
    check("t5_sb_empty", 160'(sb.size()), 0);
    @(posedge clk); #1;

    // 6: reset while both entries are full
    bus.out_ready = 1'b0;
    send(32'h41000000, 32'h41100000, 2'b00);
    send(32'h41200000, 32'h41300000, 2'b00);
    rst = 1'b1; sb.delete(); tag_m = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_valid_cleared", bus.out_valid, 0);
    check("t6_ready_in_rst",  bus.in_ready,  0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000, 2'b10);
    @(negedge clk);
    check("t6_tag_restart", bus.out_tag, 0);
    @(posedge clk); #1;

    // 7: denormal operand A
    send(32'h00000001, 32'h3F800000, 2'b00);
    @(negedge clk);
`ifdef FP_IMPORT_DENORM_FLUSH_EN
    check("t7_zeroA_flush", bus.out_special[5], 1);
    check("t7_mant_flush",  bus.out_a_mant, 0);
`else
    check("t7_zeroA_keep", bus.out_special[5], 0);
    check("t7_exp_keep",   bus.out_a_exp,  8'h01);
    check("t7_mant_keep",  bus.out_a_mant, 24'h000001);
`endif
    repeat (3) @(negedge clk);
    check("final_sb_empty", 160'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
